// File: rtl/mix_columns_sequencer_pkg.sv
// Shared types, widths and GF(2^8) helpers for the time-multiplexed AES MixColumns sequencer.
// The optional final-round pass-through is enabled with MIXCOL_BYPASS_EN.
package aes_mixcol_pkg;

    localparam int COL_W    = 32;
    localparam int STATE_W  = 128;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Column c of the state, top row in the most significant byte.
    function automatic logic [COL_W-1:0] col_sel(input logic [STATE_W-1:0] s, input logic [1:0] c);
        return s[STATE_W-1 - COL_W*c -: COL_W];
    endfunction

    function automatic logic [7:0] gf_x2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_x3(input logic [7:0] b);
        return gf_x2(b) ^ b;
    endfunction

endpackage

// File: rtl/mix_columns_sequencer_if.sv
// Valid/ready bundle carrying states into and out of the MixColumns sequencer.
// Bypass exists only when MIXCOL_BYPASS_EN is defined.
interface mix_columns_sequencer_if import aes_mixcol_pkg::*; ();

    logic               In_valid;
    logic               In_ready;
    logic [STATE_W-1:0] In;
    logic               Out_valid;
    logic               Out_ready;
    logic [STATE_W-1:0] Out;
`ifdef MIXCOL_BYPASS_EN
    logic               Bypass;
`endif

    modport master (
`ifdef MIXCOL_BYPASS_EN
        output Bypass,
`endif
        output In_valid,
        output In,
        output Out_ready,
        input  In_ready,
        input  Out_valid,
        input  Out
    );

    modport slave (
`ifdef MIXCOL_BYPASS_EN
        input  Bypass,
`endif
        input  In_valid,
        input  In,
        input  Out_ready,
        output In_ready,
        output Out_valid,
        output Out
    );

endinterface

// File: rtl/mix_columns_sequencer_unit.sv
// Registered single-column MixColumns engine: one 32-bit column in, mixed column out one cycle later.
module mix_column_unit import aes_mixcol_pkg::*; (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [COL_W-1:0] col_in,
    output logic [COL_W-1:0] col_out
);

    logic [7:0] s0, s1, s2, s3;
    logic [7:0] r0, r1, r2, r3;

    assign s0 = col_in[31:24];
    assign s1 = col_in[23:16];
    assign s2 = col_in[15:8];
    assign s3 = col_in[7:0];

    assign r0 = gf_x2(s0) ^ gf_x3(s1) ^ s2 ^ s3;
    assign r1 = s0 ^ gf_x2(s1) ^ gf_x3(s2) ^ s3;
    assign r2 = s0 ^ s1 ^ gf_x2(s2) ^ gf_x3(s3);
    assign r3 = gf_x3(s0) ^ s1 ^ s2 ^ gf_x2(s3);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            col_out <= '0;
        end else begin
            col_out <= {r0, r1, r2, r3};
        end
    end

endmodule

// File: rtl/mix_columns_sequencer.sv
// Time-multiplexes one registered column unit over the four state columns (5-edge latency, 7-cycle throughput).
// Defining MIXCOL_BYPASS_EN adds a Bypass input that passes an accepted state straight to the output.
module mix_columns_sequencer import aes_mixcol_pkg::*; (
    input logic              Clk,
    input logic              Rst_n,
    mix_columns_sequencer_if.slave bus
);

    state_t             state_q, state_d;
    logic [STATE_W-1:0] src_reg, res_reg;
    logic [1:0]         ic, cc;
    logic               issue_done;
    logic               cap_pending;
    logic               accept;
    logic               bypass_sel;
    logic [COL_W-1:0]   unit_in, unit_out;

`ifdef MIXCOL_BYPASS_EN
    assign bypass_sel = bus.Bypass;
`else
    assign bypass_sel = 1'b0;
`endif

    assign unit_in = col_sel(src_reg, ic);

    mix_column_unit u_col (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .col_in  (unit_in),
        .col_out (unit_out)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.In_valid) begin
                    accept  = 1'b1;
                    state_d = bypass_sel ? DONE : RUN;
                end
            end
            RUN: begin
                if (cap_pending && cc == 2'(NUM_COLS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.Out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The unit output trails the issue counter by one edge, so cap_pending marks a result worth capturing.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            src_reg     <= '0;
            res_reg     <= '0;
            ic          <= '0;
            cc          <= '0;
            issue_done  <= 1'b0;
            cap_pending <= 1'b0;
        end else if (accept) begin
            src_reg     <= bus.In;
            ic          <= '0;
            cc          <= '0;
            issue_done  <= 1'b0;
            cap_pending <= 1'b0;
            if (bypass_sel) begin
                res_reg <= bus.In;
            end
        end else if (state_q == RUN) begin
            cap_pending <= !issue_done;
            if (!issue_done) begin
                ic <= ic + 2'd1;
                if (ic == 2'(NUM_COLS - 1)) begin
                    issue_done <= 1'b1;
                end
            end
            if (cap_pending) begin
                res_reg[STATE_W-1 - COL_W*cc -: COL_W] <= unit_out;
                cc <= cc + 2'd1;
            end
        end
    end

    assign bus.In_ready  = (state_q == IDLE);
    assign bus.Out_valid = (state_q == DONE);
    assign bus.Out       = res_reg;

endmodule

// File: tb/tb_mix_columns_sequencer.sv
// Randomized self-checking bench for mix_columns_sequencer against a polynomial-arithmetic MixColumns model.
// Bypass scenarios are exercised when MIXCOL_BYPASS_EN is defined.
module tb_mix_columns_sequencer;

    logic Clk = 1'b0;
    logic Rst_n;
    int   tests = 0;
    int   fails = 0;

    mix_columns_sequencer_if bus ();

    mix_columns_sequencer dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s);
        logic [7:0]   coef [4][4];
        logic [127:0] r;
        logic [7:0]   acc;
        coef = '{'{8'd2, 8'd3, 8'd1, 8'd1},
                 '{8'd1, 8'd2, 8'd3, 8'd1},
                 '{8'd1, 8'd1, 8'd2, 8'd3},
                 '{8'd3, 8'd1, 8'd1, 8'd2}};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gmul(coef[row][k], s[127 - 32*c - 8*k -: 8]);
                end
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        Rst_n         = 1'b0;
        bus.In_valid  = 1'b0;
        bus.In        = '0;
        bus.Out_ready = 1'b0;
`ifdef MIXCOL_BYPASS_EN
        bus.Bypass    = 1'b0;
`endif
        repeat (2) @(negedge Clk);
        tests++;
        if (bus.In_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.In_ready);
        end
        tests++;
        if (bus.Out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.Out_valid);
        end
        tests++;
        if (bus.Out !== 128'h0) begin
            fails++;
            $display("[TB] FAIL reset_out: got %h expected 0", bus.Out);
        end
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_vectors();
        logic [127:0] vin  [2];
        logic [127:0] vexp [2];
        int lat;
        vin[0]  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        vexp[0] = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        vin[1]  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
        vexp[1] = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
        for (int i = 0; i < 2; i++) begin
            bus.In        = vin[i];
            bus.In_valid  = 1'b1;
            bus.Out_ready = 1'b1;
            @(negedge Clk);
            bus.In_valid = 1'b0;
            tests++;
            if (bus.In_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL vec%0d_busy: In_ready got %b expected 0", i, bus.In_ready);
            end
            lat = 0;
            while (bus.Out_valid !== 1'b1 && lat < 20) begin
                @(negedge Clk);
                lat++;
            end
            tests++;
            if (lat != 5) begin
                fails++;
                $display("[TB] FAIL vec%0d_latency: got %0d edges expected 5", i, lat);
            end
            tests++;
            if (bus.Out !== vexp[i]) begin
                fails++;
                $display("[TB] FAIL vec%0d_out: got %h expected %h", i, bus.Out, vexp[i]);
            end
            @(negedge Clk);
            tests++;
            if (bus.In_ready !== 1'b1 || bus.Out_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL vec%0d_idle: In_ready %b Out_valid %b expected 1 0", i, bus.In_ready, bus.Out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] a, b;
        int lat;
        a = rand_state();
        b = rand_state();
        bus.In        = a;
        bus.In_valid  = 1'b1;
        bus.Out_ready = 1'b0;
        @(negedge Clk);
        bus.In_valid = 1'b0;
        lat = 0;
        while (bus.Out_valid !== 1'b1 && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        tests++;
        if (lat != 5) begin
            fails++;
            $display("[TB] FAIL bp_latency: got %0d edges expected 5", lat);
        end
        bus.In       = b;
        bus.In_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            tests++;
            if (bus.Out !== mix_model(a) || bus.Out_valid !== 1'b1 || bus.In_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL bp_hold%0d: Out %h valid %b ready %b expected %h 1 0",
                         k, bus.Out, bus.Out_valid, bus.In_ready, mix_model(a));
            end
        end
        bus.Out_ready = 1'b1;
        @(negedge Clk);
        tests++;
        if (bus.In_ready !== 1'b1 || bus.Out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_release: In_ready %b Out_valid %b expected 1 0", bus.In_ready, bus.Out_valid);
        end
        @(negedge Clk);
        bus.In_valid = 1'b0;
        tests++;
        if (bus.In_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_accept_new: In_ready got %b expected 0", bus.In_ready);
        end
        lat = 0;
        while (bus.Out_valid !== 1'b1 && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        tests++;
        if (bus.Out_valid !== 1'b1 || bus.Out !== mix_model(b)) begin
            fails++;
            $display("[TB] FAIL bp_new_out: got %h valid %b expected %h", bus.Out, bus.Out_valid, mix_model(b));
        end
        @(negedge Clk);
    endtask

    task automatic test_reset_mid();
        logic [127:0] a, b;
        int lat;
        a = rand_state();
        b = rand_state();
        bus.In        = a;
        bus.In_valid  = 1'b1;
        bus.Out_ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        bus.In_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Rst_n = 1'b0;
        #1;
        tests++;
        if (bus.Out_valid !== 1'b0 || bus.Out !== 128'h0 || bus.In_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midreset: Out_valid %b Out %h In_ready %b expected 0 0 1",
                     bus.Out_valid, bus.Out, bus.In_ready);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        bus.In       = b;
        bus.In_valid = 1'b1;
        @(negedge Clk);
        bus.In_valid = 1'b0;
        lat = 0;
        while (bus.Out_valid !== 1'b1 && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        tests++;
        if (lat != 5 || bus.Out !== mix_model(b)) begin
            fails++;
            $display("[TB] FAIL postreset_out: got %h after %0d edges expected %h after 5",
                     bus.Out, lat, mix_model(b));
        end
        @(negedge Clk);
    endtask

`ifdef MIXCOL_BYPASS_EN
    task automatic test_bypass();
        logic [127:0] a, b;
        int lat;
        a = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        b = rand_state();
        bus.In        = a;
        bus.Bypass    = 1'b1;
        bus.In_valid  = 1'b1;
        bus.Out_ready = 1'b1;
        @(negedge Clk);
        bus.In_valid = 1'b0;
        bus.Bypass   = 1'b0;
        tests++;
        if (bus.Out_valid !== 1'b1 || bus.Out !== a) begin
            fails++;
            $display("[TB] FAIL bypass_out: got %h valid %b expected %h 1", bus.Out, bus.Out_valid, a);
        end
        @(negedge Clk);
        bus.In       = b;
        bus.In_valid = 1'b1;
        @(negedge Clk);
        bus.In_valid = 1'b0;
        lat = 0;
        while (bus.Out_valid !== 1'b1 && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        tests++;
        if (lat != 5 || bus.Out !== mix_model(b)) begin
            fails++;
            $display("[TB] FAIL bypass_off_out: got %h after %0d edges expected %h after 5",
                     bus.Out, lat, mix_model(b));
        end
        @(negedge Clk);
    endtask
`endif

    task automatic test_random();
        logic [127:0] a;
        int lat;
        int stall;
        for (int n = 0; n < 8; n++) begin
            a     = rand_state();
            stall = int'($urandom_range(0, 3));
            bus.In        = a;
            bus.In_valid  = 1'b1;
            bus.Out_ready = (stall == 0);
            @(negedge Clk);
            bus.In_valid = 1'b0;
            lat = 0;
            while (bus.Out_valid !== 1'b1 && lat < 20) begin
                @(negedge Clk);
                lat++;
            end
            tests++;
            if (lat != 5 || bus.Out !== mix_model(a)) begin
                fails++;
                $display("[TB] FAIL rand%0d_out: got %h after %0d edges expected %h after 5",
                         n, bus.Out, lat, mix_model(a));
            end
            repeat (stall) @(negedge Clk);
            if (stall != 0) begin
                tests++;
                if (bus.Out_valid !== 1'b1 || bus.Out !== mix_model(a)) begin
                    fails++;
                    $display("[TB] FAIL rand%0d_stall: got %h valid %b expected %h 1",
                             n, bus.Out, bus.Out_valid, mix_model(a));
                end
            end
            bus.Out_ready = 1'b1;
            @(negedge Clk);
            tests++;
            if (bus.In_ready !== 1'b1) begin
                fails++;
                $display("[TB] FAIL rand%0d_idle: In_ready got %b expected 1", n, bus.In_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] q    [3];
        logic [127:0] gotv [3];
        int           stamp [3];
        int           idx, got, cyc;
        logic         prev_ready;
        for (int i = 0; i < 3; i++) q[i] = rand_state();
        idx           = 0;
        got           = 0;
        cyc           = 0;
        bus.In        = q[0];
        bus.In_valid  = 1'b1;
        bus.Out_ready = 1'b1;
        prev_ready    = bus.In_ready;
        while (got < 3 && cyc < 100) begin
            @(negedge Clk);
            cyc++;
            if (prev_ready && bus.In_valid) begin
                idx++;
                if (idx < 3) bus.In = q[idx];
                else         bus.In_valid = 1'b0;
            end
            if (bus.Out_valid === 1'b1) begin
                gotv[got]  = bus.Out;
                stamp[got] = cyc;
                got++;
            end
            prev_ready = bus.In_ready;
        end
        bus.In_valid = 1'b0;
        tests++;
        if (got != 3) begin
            fails++;
            $display("[TB] FAIL b2b_count: got %0d outputs expected 3", got);
        end
        for (int i = 0; i < got; i++) begin
            tests++;
            if (gotv[i] !== mix_model(q[i])) begin
                fails++;
                $display("[TB] FAIL b2b_out%0d: got %h expected %h", i, gotv[i], mix_model(q[i]));
            end
        end
        for (int i = 1; i < got; i++) begin
            tests++;
            if (stamp[i] - stamp[i-1] != 7) begin
                fails++;
                $display("[TB] FAIL b2b_spacing%0d: got %0d cycles expected 7", i, stamp[i] - stamp[i-1]);
            end
        end
        @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
`ifdef MIXCOL_BYPASS_EN
        test_bypass();
`endif
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
